mem_stage_pipe: RTL and testbench

- Parametrised successor of the single-cycle MEM stage.
- Contains a byte-addressable data memory, byte/half/word load-store with sign/zero extension, and a configurable multi-cycle memory latency with a stall handshake to the hazard unit.
- Includes the MEM/WB pipeline register and combinational forwarding taps.
- Sits between the EX/MEM register and the WB stage.

---
 rtl/mem_stage_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - MEM stage: byte-addressable data memory, wait-state FSM, MEM/WB register, forwarding taps
//
// Optional feature macro: MEM_STAGE_PERF_EN (adds perf_access_cnt / perf_stall_cnt outputs)
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   ex_reg_write_in      register-write control from EX/MEM
//   ex_mem_to_reg_in     writeback mux select from EX/MEM
//   mem_read, mem_write  load / store request
//   mem_size             00 byte, 01 half, 10/11 word
//   mem_unsigned         1 = zero-extend loads, 0 = sign-extend
//   address              ALU result / byte address (little-endian)
//   write_data           store data, low bytes used for byte/half
//   write_register       destination register index
//   mem_stall            hold upstream stages while high
//   fwd_*                combinational forwarding taps of the EX/MEM values
//   wb_*                 MEM/WB pipeline register outputs
//   perf_access_cnt      completed aligned accesses (MEM_STAGE_PERF_EN only)
//   perf_stall_cnt       cycles with mem_stall high (MEM_STAGE_PERF_EN only)

module mem_stage_pipe #(
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 0,
    parameter int REG_W   = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ex_reg_write_in,
    input  logic             ex_mem_to_reg_in,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic [REG_W-1:0] write_register,
    output logic             mem_stall,
    output logic             fwd_reg_write,
    output logic [REG_W-1:0] fwd_reg_rd,
    output logic [31:0]      fwd_alu_result,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [31:0]      wb_read_data,
    output logic [31:0]      wb_alu_result,
    output logic [REG_W-1:0] wb_write_reg,
    output logic             wb_misaligned
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]      perf_access_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    // Counter reload value; the WAIT state itself accounts for one of the MEM_LAT cycles.
    localparam logic [3:0] LAT_LOAD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic [31:0]   dmem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          is_mem;
    logic          misaligned;
    logic          access;
    logic          complete;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_ext;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;

    assign fwd_reg_write  = ex_reg_write_in;
    assign fwd_reg_rd     = write_register;
    assign fwd_alu_result = address;

    assign word_idx   = address[AW+1:2];
    assign lane       = address[1:0];
    assign is_mem     = mem_read | mem_write;
    assign misaligned = is_mem && (((mem_size == 2'b01) && address[0]) ||
                                   (mem_size[1] && (address[1:0] != 2'b00)));
    assign access     = is_mem && !misaligned;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (access && (MEM_LAT > 0)) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic. Both outputs are gated by RST so an in-flight access is
    // dropped at once and the stall releases while reset is still asserted.
    always_comb begin
        mem_stall = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                mem_stall = RST && access && (MEM_LAT > 0);
                complete  = RST && access && (MEM_LAT == 0);
            end
            S_WAIT: begin
                mem_stall = RST && (cnt != 4'd0);
                complete  = RST && (cnt == 4'd0) && access;
            end
            default: ;
        endcase
    end

    // Store lane selection: narrow data is replicated so each enabled lane
    // simply takes its own byte position.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = write_data;
        case (mem_size)
            2'b00: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en  = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (complete && mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) dmem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // Load path reads the current word, so a combined read+write returns
    // the pre-store contents.
    assign rd_word = dmem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{address[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = rd_word;
        case (mem_size)
            2'b00:   load_ext = mem_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = mem_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    // MEM/WB register; a stalled cycle loads a bubble.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_write_reg  <= '0;
            wb_misaligned <= 1'b0;
        end else if (mem_stall) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= address;
            wb_write_reg  <= write_register;
            wb_misaligned <= 1'b0;
        end else begin
            wb_reg_write  <= ex_reg_write_in && !misaligned;
            wb_mem_to_reg <= ex_mem_to_reg_in;
            wb_read_data  <= (mem_read && !misaligned) ? load_ext : 32'd0;
            wb_alu_result <= address;
            wb_write_reg  <= write_register;
            wb_misaligned <= misaligned;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_access_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (complete)  perf_access_cnt <= perf_access_cnt + 32'd1;
            if (mem_stall) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb/tb_mem_stage_pipe.sv - self-checking bench for mem_stage_pipe (MEM_LAT=0 and MEM_LAT=3 instances)

module tb_mem_stage_pipe;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } in_t;

    typedef struct {
        in_t         v;
        logic [31:0] d;
        logic        rw;
        logic        mis;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    in_t in0, in3;

    logic        stall0, frw0, wrw0, wm2r0, wmis0;
    logic [4:0]  frd0, wwreg0;
    logic [31:0] falu0, wrd0, walu0;
    logic        stall3, frw3, wrw3, wm2r3, wmis3;
    logic [4:0]  frd3, wwreg3;
    logic [31:0] falu3, wrd3, walu3;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0] acc0, stl0, acc3, stl3;
`endif

    mem_stage_pipe #(.DEPTH(1024), .MEM_LAT(0), .REG_W(5)) dut0 (
        .CLK(CLK), .RST(RST),
        .ex_reg_write_in(in0.rw), .ex_mem_to_reg_in(in0.m2r),
        .mem_read(in0.rd), .mem_write(in0.wr), .mem_size(in0.size),
        .mem_unsigned(in0.uns), .address(in0.addr), .write_data(in0.wdata),
        .write_register(in0.wreg),
        .mem_stall(stall0), .fwd_reg_write(frw0), .fwd_reg_rd(frd0),
        .fwd_alu_result(falu0), .wb_reg_write(wrw0), .wb_mem_to_reg(wm2r0),
        .wb_read_data(wrd0), .wb_alu_result(walu0), .wb_write_reg(wwreg0),
        .wb_misaligned(wmis0)
`ifdef MEM_STAGE_PERF_EN
        , .perf_access_cnt(acc0), .perf_stall_cnt(stl0)
`endif
    );

    mem_stage_pipe #(.DEPTH(1024), .MEM_LAT(3), .REG_W(5)) dut3 (
        .CLK(CLK), .RST(RST),
        .ex_reg_write_in(in3.rw), .ex_mem_to_reg_in(in3.m2r),
        .mem_read(in3.rd), .mem_write(in3.wr), .mem_size(in3.size),
        .mem_unsigned(in3.uns), .address(in3.addr), .write_data(in3.wdata),
        .write_register(in3.wreg),
        .mem_stall(stall3), .fwd_reg_write(frw3), .fwd_reg_rd(frd3),
        .fwd_alu_result(falu3), .wb_reg_write(wrw3), .wb_mem_to_reg(wm2r3),
        .wb_read_data(wrd3), .wb_alu_result(walu3), .wb_write_reg(wwreg3),
        .wb_misaligned(wmis3)
`ifdef MEM_STAGE_PERF_EN
        , .perf_access_cnt(acc3), .perf_stall_cnt(stl3)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int acc0_exp = 0;
    int acc3_exp = 0;
    int stl3_exp = 0;

    // Reference byte memories (index 0: dut0, 1: dut3) with written-byte tracking.
    logic [7:0] ref_mem [2][4096];
    logic       ref_vld [2][4096];

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t op(input logic rw, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] a, input logic [31:0] wd);
        in_t v;
        v.rw = rw; v.m2r = rd; v.rd = rd; v.wr = wr; v.size = sz; v.uns = uns;
        v.addr = a; v.wdata = wd; v.wreg = 5'(a[6:2] + 5'd1);
        return v;
    endfunction

    task automatic add(input in_t v, input logic [31:0] d, input logic rw, input logic mis);
        vec_t e;
        e.v = v; e.d = d; e.rw = rw; e.mis = mis;
        tbl.push_back(e);
    endtask

    function automatic in_t rnd_op();
        in_t v;
        int kind;
        kind = $urandom_range(0, 3);
        v.rw = 1'($urandom); v.m2r = 1'($urandom);
        v.rd = (kind == 1) || (kind == 3);
        v.wr = (kind == 2) || (kind == 3);
        v.size = 2'($urandom_range(0, 3)); v.uns = 1'($urandom);
        v.addr = $urandom & 32'hFFFF_F03F;
        v.wdata = $urandom; v.wreg = 5'($urandom);
        return v;
    endfunction

    // Behavioural model: sizes in bytes, alignment by modulo, memory as a byte array.
    task automatic model(input int k, input in_t v, output logic [31:0] d, output logic rwo,
                         output logic miso, output logic known);
        int n, base;
        n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        base = int'(v.addr % 32'd4096);
        miso = (v.rd || v.wr) && ((v.addr % n) != 0);
        d = 32'd0;
        known = 1'b1;
        if (v.rd && !miso) begin
            for (int i = 0; i < n; i++) begin
                if (!ref_vld[k][base+i]) known = 1'b0;
                d = d | (32'(ref_mem[k][base+i]) << (8*i));
            end
            if (!v.uns && n < 4 && d[8*n-1]) d = d | (32'hFFFF_FFFF << (8*n));
        end
        if (v.wr && !miso) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[k][base+i] = 8'(v.wdata >> (8*i));
                ref_vld[k][base+i] = 1'b1;
            end
        end
        rwo = v.rw && !miso;
    endtask

    task automatic step0(input in_t v, input logic [31:0] ed, input logic erw, input logic emis,
                         input logic dchk, input string tag);
        in0 = v;
        #1;
        chk({tag, "_stall"}, stall0, 0);
        chk({tag, "_fwd_rw"}, frw0, v.rw);
        chk({tag, "_fwd_rd"}, frd0, v.wreg);
        chk({tag, "_fwd_alu"}, falu0, v.addr);
        @(posedge CLK); #1;
        if (dchk) chk({tag, "_rdata"}, wrd0, ed);
        chk({tag, "_wb_rw"}, wrw0, erw);
        chk({tag, "_wb_mis"}, wmis0, emis);
        chk({tag, "_wb_m2r"}, wm2r0, v.m2r);
        chk({tag, "_wb_alu"}, walu0, v.addr);
        chk({tag, "_wb_reg"}, wwreg0, v.wreg);
        if ((v.rd || v.wr) && !emis) acc0_exp++;
    endtask

    // Holds inputs until the stall clears (bounded), then takes the completion edge.
    task automatic run3(input in_t v, output int stalls);
        in3 = v;
        #1;
        stalls = 0;
        while (stall3 === 1'b1 && stalls < 20) begin
            @(posedge CLK); #1;
            stalls++;
            chk("bubble_rw", wrw3, 0);
            chk("bubble_m2r", wm2r3, 0);
            chk("bubble_mis", wmis3, 0);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        logic erw, emis, known;
        int stalls;
        in_t v;

        RST = 1'b0;
        in0 = '0;
        in3 = '0;
        #3;
        chk("rst_stall0", stall0, 0);
        chk("rst_rw0", wrw0, 0);
        chk("rst_m2r0", wm2r0, 0);
        chk("rst_rd0", wrd0, 0);
        chk("rst_alu0", walu0, 0);
        chk("rst_reg0", wwreg0, 0);
        chk("rst_mis0", wmis0, 0);
        chk("rst_stall3", stall3, 0);
        chk("rst_rw3", wrw3, 0);
        chk("rst_rd3", wrd3, 0);
        chk("rst_mis3", wmis3, 0);
`ifdef MEM_STAGE_PERF_EN
        chk("rst_acc3", acc3, 0);
        chk("rst_stl3", stl3, 0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Directed vectors on the zero-latency instance.
        add(op(0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF), 32'h0, 0, 0);
        add(op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0), 32'hDEADBEEF, 1, 0);
        add(op(0, 0, 1, 2'd2, 0, 32'h10, 32'h11223344), 32'h0, 0, 0);
        add(op(0, 0, 1, 2'd0, 0, 32'h13, 32'h12345680), 32'h0, 0, 0);
        add(op(1, 1, 0, 2'd0, 0, 32'h13, 32'h0), 32'hFFFFFF80, 1, 0);
        add(op(1, 1, 0, 2'd0, 1, 32'h13, 32'h0), 32'h00000080, 1, 0);
        add(op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0), 32'h80223344, 1, 0);
        add(op(1, 1, 0, 2'd1, 0, 32'h12, 32'h0), 32'hFFFF8022, 1, 0);
        add(op(1, 1, 0, 2'd1, 1, 32'h12, 32'h0), 32'h00008022, 1, 0);
        add(op(0, 0, 1, 2'd2, 0, 32'h20, 32'h55667788), 32'h0, 0, 0);
        add(op(1, 0, 1, 2'd1, 0, 32'h21, 32'h0000A5A5), 32'h0, 0, 1);
        add(op(1, 1, 0, 2'd2, 0, 32'h20, 32'h0), 32'h55667788, 1, 0);
        add(op(1, 1, 0, 2'd2, 0, 32'h22, 32'h0), 32'h0, 0, 1);
        add(op(0, 0, 1, 2'd1, 0, 32'h22, 32'h0000BEEF), 32'h0, 0, 0);
        add(op(1, 1, 0, 2'd3, 0, 32'h20, 32'h0), 32'hBEEF7788, 1, 0);
        add(op(0, 0, 1, 2'd2, 0, 32'h1000, 32'h12345678), 32'h0, 0, 0);
        add(op(1, 1, 0, 2'd2, 0, 32'h0, 32'h0), 32'h12345678, 1, 0);
        add(op(1, 1, 1, 2'd2, 0, 32'h10, 32'hCAFEF00D), 32'h80223344, 1, 0);
        add(op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0), 32'hCAFEF00D, 1, 0);
        add(op(1, 0, 0, 2'd3, 0, 32'h12345677, 32'h0), 32'h0, 1, 0);
        foreach (tbl[i]) step0(tbl[i].v, tbl[i].d, tbl[i].rw, tbl[i].mis, 1'b1, $sformatf("vec%0d", i));

        // Randomized traffic on the zero-latency instance against the byte model.
        for (int i = 0; i < 4096; i++) begin
            ref_vld[0][i] = 1'b0;
            ref_vld[1][i] = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            v = rnd_op();
            model(0, v, ed, erw, emis, known);
            step0(v, ed, erw, emis, known, "rnd0");
        end
        in0 = '0;
`ifdef MEM_STAGE_PERF_EN
        chk("perf_acc0", acc0, acc0_exp);
        chk("perf_stl0", stl0, 0);
`endif

        // Latency-3 instance: directed sequences.
        run3(op(0, 0, 1, 2'd2, 0, 32'h40, 32'h11111111), stalls);
        chk("lat_sw_stalls", stalls, 3);
        run3(op(1, 1, 0, 2'd2, 0, 32'h40, 32'h0), stalls);
        chk("lat_lw_stalls", stalls, 3);
        chk("lat_lw_data", wrd3, 32'h11111111);
        chk("lat_lw_rw", wrw3, 1);
        chk("lat_lw_m2r", wm2r3, 1);
        run3(op(1, 1, 0, 2'd2, 0, 32'h42, 32'h0), stalls);
        chk("lat_mis_stalls", stalls, 0);
        chk("lat_mis_flag", wmis3, 1);
        chk("lat_mis_rw", wrw3, 0);
        chk("lat_mis_data", wrd3, 0);
        run3(op(1, 0, 0, 2'd2, 0, 32'h77, 32'h0), stalls);
        chk("lat_alu_stalls", stalls, 0);
        chk("lat_alu_rw", wrw3, 1);
        chk("lat_alu_res", walu3, 32'h77);

        // Reset pulsed during the second stall cycle of a store.
        in3 = op(0, 0, 1, 2'd2, 0, 32'h40, 32'h22222222);
        #1;
        chk("rstw_stall_c1", stall3, 1);
        @(posedge CLK); #1;
        chk("rstw_stall_c2", stall3, 1);
        RST = 1'b0;
        #1;
        chk("rstw_stall_drop", stall3, 0);
        chk("rstw_rw", wrw3, 0);
        chk("rstw_m2r", wm2r3, 0);
        chk("rstw_rd", wrd3, 0);
        chk("rstw_alu", walu3, 0);
        chk("rstw_reg", wwreg3, 0);
        chk("rstw_mis", wmis3, 0);
`ifdef MEM_STAGE_PERF_EN
        chk("rstw_acc", acc3, 0);
        chk("rstw_stl", stl3, 0);
`endif
        in3 = '0;
        in0 = '0;
        @(posedge CLK); #1;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        run3(op(1, 1, 0, 2'd2, 0, 32'h40, 32'h0), stalls);
        chk("rstw_old_stalls", stalls, 3);
        chk("rstw_old_data", wrd3, 32'h11111111);
        acc3_exp = 1;
        stl3_exp = 3;

        // Randomized traffic on the latency-3 instance.
        for (int i = 0; i < 150; i++) begin
            v = rnd_op();
            model(1, v, ed, erw, emis, known);
            run3(v, stalls);
            chk("rnd3_stalls", stalls, ((v.rd || v.wr) && !emis) ? 3 : 0);
            if (known) chk("rnd3_rdata", wrd3, ed);
            chk("rnd3_rw", wrw3, erw);
            chk("rnd3_mis", wmis3, emis);
            chk("rnd3_m2r", wm2r3, v.m2r);
            chk("rnd3_alu", walu3, v.addr);
            chk("rnd3_reg", wwreg3, v.wreg);
            if ((v.rd || v.wr) && !emis) begin
                acc3_exp++;
                stl3_exp += 3;
            end
        end
        in3 = '0;
`ifdef MEM_STAGE_PERF_EN
        #1;
        chk("perf_acc3", acc3, acc3_exp);
        chk("perf_stl3", stl3, stl3_exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
